// File: rtl/rnd_collector_pkg.sv
// Shared definitions for the random-word collector and its upstream packer pairing.
package rnd_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } collector_state_e;

    localparam int unsigned DefInW          = 32;
    localparam int unsigned DefWordsPerEntry = 8;

endpackage

// File: rtl/rnd_word_collector.sv
// Gathers WordsPerEntry upstream words into one wide entry, handed to the core on request.
module rnd_word_collector
    import rnd_collector_pkg::*;
#(
    parameter int unsigned InW            = DefInW,
    parameter int unsigned WordsPerEntry  = DefWordsPerEntry,
    parameter bit          ClearOnConsume = 1'b1,
    localparam int unsigned OutW          = InW * WordsPerEntry,
    localparam int unsigned CntW          = $clog2(WordsPerEntry)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              req_i,
    input  logic              in_valid_i,
    input  logic [InW-1:0]    in_data_i,
    output logic              in_ready_o,
    output logic              valid_o,
    output logic [OutW-1:0]   data_o,
    input  logic              consume_i,
    output logic [CntW:0]     cnt_o,
    output logic              err_o
);

    collector_state_e     state_q;
    logic [CntW:0]        cnt_q;
    logic [OutW-1:0]      data_q;
    logic                 err_q;
    logic [WordsPerEntry-1:0] slice_we;
    logic                 accept;
    logic                 last_word;

    // Handshake is decoded purely from the state register, never from in_valid_i.
    assign in_ready_o = (state_q == ST_COLLECT);
    assign valid_o    = (state_q == ST_FULL);
    assign data_o     = data_q;
    assign cnt_o      = cnt_q;
    assign err_o      = err_q;

    assign accept    = in_valid_i && in_ready_o;
    assign last_word = (cnt_q == (CntW+1)'(WordsPerEntry - 1));

    always_comb begin
        slice_we = '0;
        for (int k = 0; k < WordsPerEntry; k++) begin
            slice_we[k] = accept && (cnt_q == (CntW+1)'(k));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= consume_i && (state_q != ST_FULL);
            for (int k = 0; k < WordsPerEntry; k++) begin
                if (slice_we[k]) data_q[k*InW +: InW] <= in_data_i;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        state_q <= ST_COLLECT;
                        cnt_q   <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        cnt_q <= cnt_q + (CntW+1)'(1);
                        if (last_word) state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (consume_i) begin
                        cnt_q   <= '0;
                        state_q <= req_i ? ST_COLLECT : ST_IDLE;
                        if (ClearOnConsume) data_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rnd_word_collector.sv
// Scoreboard bench: expected entries are queued at stimulus time and matched when valid_o rises.
module tb_rnd_word_collector;

    localparam int InW  = 32;
    localparam int WPE  = 8;
    localparam int OutW = InW * WPE;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            clr_i = 1'b0;
    logic            req_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic [InW-1:0]  in_data_i = '0;
    logic            consume_i = 1'b0;

    logic            a_ready, a_valid, a_err;
    logic [OutW-1:0] a_data;
    logic [3:0]      a_cnt;
    logic            b_ready, b_valid, b_err;
    logic [OutW-1:0] b_data;
    logic [3:0]      b_cnt;

    int checks = 0;
    int failures = 0;
    logic [OutW-1:0] exp_q[$];
    logic            prev_valid = 1'b0;

    always #5 clk = ~clk;

    rnd_word_collector #(.InW(InW), .WordsPerEntry(WPE), .ClearOnConsume(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .req_i(req_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(a_ready),
        .valid_o(a_valid), .data_o(a_data), .consume_i(consume_i),
        .cnt_o(a_cnt), .err_o(a_err)
    );

    rnd_word_collector #(.InW(InW), .WordsPerEntry(WPE), .ClearOnConsume(1'b0)) dut_hold (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .req_i(req_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(b_ready),
        .valid_o(b_valid), .data_o(b_data), .consume_i(consume_i),
        .cnt_o(b_cnt), .err_o(b_err)
    );

    task automatic chk(input string nm, input logic [OutW-1:0] act, input logic [OutW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OutW-1:0] build(input logic [InW-1:0] base, input logic [InW-1:0] step);
        logic [OutW-1:0] e;
        e = '0;
        for (int k = 0; k < WPE; k++) e[k*InW +: InW] = base + InW'(k) * step;
        return e;
    endfunction

    task automatic stream(input logic [InW-1:0] base, input logic [InW-1:0] step);
        for (int k = 0; k < WPE; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = base + InW'(k) * step;
            tick();
            chk("stream_valid", {255'd0, a_valid}, {255'd0, k == WPE - 1});
        end
        in_valid_i = 1'b0;
    endtask

    // Monitor: every rising edge of valid_o must match the oldest queued entry.
    always @(negedge clk) begin
        if (a_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", a_data, '0);
                if (a_data == '0) begin
                    failures++;
                    $display("FAIL unexpected_entry actual=valid required=no_entry");
                end
            end else begin
                chk("entry_data", a_data, exp_q.pop_front());
            end
        end
        prev_valid = a_valid;
    end

    initial begin
        logic [OutW-1:0] e1, e3, e4;
        logic [3:0] held;

        tick(); tick();
        rst_i = 1'b0;
        chk("rst_ready", {255'd0, a_ready}, '0);
        chk("rst_valid", {255'd0, a_valid}, '0);
        chk("rst_data",  a_data, '0);
        chk("rst_cnt",   {252'd0, a_cnt}, '0);
        chk("rst_err",   {255'd0, a_err}, '0);

        // Back-to-back stream; valid_o on the 9th edge counting the request edge.
        e1 = build(32'h11111111, 32'h11111111);
        exp_q.push_back(e1);
        req_i = 1'b1; tick(); req_i = 1'b0;
        chk("t1_ready_after_req", {255'd0, a_ready}, 256'd1);
        chk("t1_cnt_after_req", {252'd0, a_cnt}, '0);
        stream(32'h11111111, 32'h11111111);
        chk("t1_literal_data", a_data,
            256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
        chk("t1_cnt_full", {252'd0, a_cnt}, 256'd8);
        chk("t1_ready_full", {255'd0, a_ready}, '0);

        consume_i = 1'b1; tick(); consume_i = 1'b0;
        chk("t1_cons_valid", {255'd0, a_valid}, '0);
        chk("t1_cons_data",  a_data, '0);
        chk("t1_cons_cnt",   {252'd0, a_cnt}, '0);
        chk("t1_cons_err",   {255'd0, a_err}, '0);
        chk("hold_cons_data", b_data, e1);
        chk("hold_cons_valid", {255'd0, b_valid}, '0);

        // Alternate-cycle stalls: same entry, cnt frozen across gaps.
        exp_q.push_back(e1);
        req_i = 1'b1; tick(); req_i = 1'b0;
        for (int k = 0; k < WPE; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'h11111111 * InW'(k + 1);
            tick();
            chk("t2_valid", {255'd0, a_valid}, {255'd0, k == WPE - 1});
            held = a_cnt;
            in_valid_i = 1'b0;
            in_data_i  = 32'hFFFFFFFF;
            tick();
            chk("t2_cnt_gap", {252'd0, a_cnt}, 256'(k + 1));
            chk("t2_cnt_hold", {252'd0, a_cnt}, {252'd0, held});
        end
        chk("t2_data", a_data, e1);

        // Consume with request: immediate refill.
        e3 = build(32'hC0DE0000, 32'h00000101);
        exp_q.push_back(e3);
        consume_i = 1'b1; req_i = 1'b1; tick(); consume_i = 1'b0; req_i = 1'b0;
        chk("t3_valid", {255'd0, a_valid}, '0);
        chk("t3_ready", {255'd0, a_ready}, 256'd1);
        chk("t3_data",  a_data, '0);
        stream(32'hC0DE0000, 32'h00000101);
        chk("t3_new_data", a_data, e3);
        consume_i = 1'b1; tick(); consume_i = 1'b0;

        // Flush after 5 words; the word offered alongside clr_i must be dropped.
        req_i = 1'b1; tick(); req_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid_i = 1'b1; in_data_i = 32'hBAD00000 + InW'(k); tick();
        end
        chk("t4_cnt5", {252'd0, a_cnt}, 256'd5);
        clr_i = 1'b1; in_data_i = 32'hDEADBEEF; tick();
        clr_i = 1'b0; in_valid_i = 1'b0;
        chk("t4_ready", {255'd0, a_ready}, '0);
        chk("t4_valid", {255'd0, a_valid}, '0);
        chk("t4_cnt",   {252'd0, a_cnt}, '0);
        chk("t4_data",  a_data, '0);
        chk("hold_clr_data", b_data, '0);
        tick();
        chk("t4_idle_cnt", {252'd0, a_cnt}, '0);
        e4 = build(32'h5A5A0000, 32'h00000011);
        exp_q.push_back(e4);
        req_i = 1'b1; tick(); req_i = 1'b0;
        stream(32'h5A5A0000, 32'h00000011);
        chk("t4_fresh_data", a_data, e4);
        consume_i = 1'b1; tick(); consume_i = 1'b0;
        chk("hold_fresh_data", b_data, e4);

        // Stray consume in IDLE: one-cycle error pulse only.
        tick();
        chk("t5_err_before", {255'd0, a_err}, '0);
        consume_i = 1'b1; tick(); consume_i = 1'b0;
        chk("t5_err_pulse", {255'd0, a_err}, 256'd1);
        chk("t5_ready", {255'd0, a_ready}, '0);
        chk("t5_valid", {255'd0, a_valid}, '0);
        chk("t5_data",  a_data, '0);
        chk("hold_err_data", b_data, e4);
        chk("hold_err_pulse", {255'd0, b_err}, 256'd1);
        tick();
        chk("t5_err_end", {255'd0, a_err}, '0);
        chk("t5_cnt", {252'd0, a_cnt}, '0);

        tick();
        chk("sb_drained", 256'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
